// File: rtl/out_vc_state_ctrl_pkg.sv
// Shared router definitions for the output-VC state controller.
// Holds the router-wide sizing defaults (N ports, V VCs per port, downstream
// buffer depth) and the per-VC lifecycle state encoding.
package out_vc_state_ctrl_pkg;

  localparam int unsigned ROUTER_N          = 5;  // router output ports
  localparam int unsigned ROUTER_V          = 4;  // virtual channels per port
  localparam int unsigned ROUTER_BUF_DEPTH  = 4;  // downstream slots per VC

  // Output-VC lifecycle: free -> owned by a packet -> waiting for credits.
  typedef enum logic [1:0] {
    VC_IDLE   = 2'd0,
    VC_ACTIVE = 2'd1,
    VC_DRAIN  = 2'd2
  } vc_state_e;

endpackage

// File: rtl/out_vc_state_ctrl_slot.sv
// out_vc_slot: lifecycle FSM, credit counter and error term for one output VC.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   i_alloc          : one-hot-qualified allocation aimed at this VC
//   i_flit, i_tail   : one-hot-qualified flit departure on this VC, tail flag
//   i_credit         : one-hot-qualified credit return on this VC
//   o_state          : current FSM state (debug visibility)
//   o_cnt            : current credit count
//   o_avail          : VC is IDLE
//   o_credit_avail   : credit count nonzero
//   o_err            : an event aimed at this VC this cycle is illegal
module out_vc_slot
  import out_vc_state_ctrl_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = ROUTER_BUF_DEPTH,
  parameter int unsigned CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_alloc,
  input  logic          i_flit,
  input  logic          i_tail,
  input  logic          i_credit,
  output vc_state_e     o_state,
  output logic [CW-1:0] o_cnt,
  output logic          o_avail,
  output logic          o_credit_avail,
  output logic          o_err
);

  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  vc_state_e     r_state;
  vc_state_e     w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  logic w_alloc_ok;
  logic w_flit_ok;
  logic w_cred_ok;

  assign w_alloc_ok = i_alloc && (r_state == VC_IDLE);
  assign w_flit_ok  = i_flit && (r_state == VC_ACTIVE) && (r_cnt != '0);
  // A credit at full count is only acceptable when a legal flit frees a slot
  // in the same cycle, so the count never exceeds BUF_DEPTH.
  assign w_cred_ok  = i_credit && ((r_cnt < FULL) || ((r_cnt == FULL) && w_flit_ok));
  assign w_cnt_next = r_cnt - CW'(w_flit_ok) + CW'(w_cred_ok);

  // State register and credit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= VC_IDLE;
      r_cnt   <= FULL;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic. DRAIN releases the VC once every downstream slot has
  // been returned, judged on the post-update count.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      VC_IDLE:   if (w_alloc_ok) w_state_next = VC_ACTIVE;
      VC_ACTIVE: if (w_flit_ok && i_tail) w_state_next = VC_DRAIN;
      VC_DRAIN:  if (w_cnt_next == FULL) w_state_next = VC_IDLE;
      default:   w_state_next = VC_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    o_state        = r_state;
    o_cnt          = r_cnt;
    o_avail        = (r_state == VC_IDLE);
    o_credit_avail = (r_cnt != '0);
    o_err          = (i_alloc && !w_alloc_ok) || (i_flit && !w_flit_ok) ||
                     (i_credit && !w_cred_ok);
  end

endmodule

// File: rtl/out_vc_state_ctrl.sv
// out_vc_state_ctrl: output-VC state controller for one router output port.
// Tracks ownership and downstream credits of each of the V output VCs and
// publishes availability to the VC and switch allocators.
// Event signalling: allocValid, flitSent and creditIn are single-cycle
// strobes with no backpressure; the accompanying one-hot vector is sampled
// only in a cycle whose strobe is high, and every strobe is consumed on the
// rising edge it is presented at. Illegal events are dropped and latch
// protoErr until reset.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   allocValid, allocVC      : VC allocator grant, one-hot VC
//   flitSent, flitVC, flitTail : flit departure, one-hot VC, tail flag
//   creditIn, creditVC       : credit return, one-hot VC
//   outVCAvailable           : per-VC IDLE flag
//   creditAvail              : per-VC nonzero-credit flag
//   creditCnt                : packed counts, VC j at [j*CW +: CW]
//   protoErr                 : sticky protocol-violation flag
//   dbgState                 : packed FSM states, VC j at [j*2 +: 2]
module out_vc_state_ctrl
  import out_vc_state_ctrl_pkg::*;
#(
  parameter int unsigned V         = ROUTER_V,
  parameter int unsigned BUF_DEPTH = ROUTER_BUF_DEPTH,
  parameter int unsigned CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            allocValid,
  input  logic [V-1:0]    allocVC,
  input  logic            flitSent,
  input  logic [V-1:0]    flitVC,
  input  logic            flitTail,
  input  logic            creditIn,
  input  logic [V-1:0]    creditVC,
  output logic [V-1:0]    outVCAvailable,
  output logic [V-1:0]    creditAvail,
  output logic [V*CW-1:0] creditCnt,
  output logic            protoErr,
  output logic [2*V-1:0]  dbgState
);

  logic w_alloc_oh;
  logic w_flit_oh;
  logic w_cred_oh;
  logic w_vec_err;
  logic [V-1:0] w_slot_err;
  logic r_proto_err;

  assign w_alloc_oh = $onehot(allocVC);
  assign w_flit_oh  = $onehot(flitVC);
  assign w_cred_oh  = $onehot(creditVC);

  // A strobe carrying a malformed vector reaches no slot at all.
  assign w_vec_err = (allocValid && !w_alloc_oh) || (flitSent && !w_flit_oh) ||
                     (creditIn && !w_cred_oh);

  for (genvar j = 0; j < V; j++) begin : g_slot
    vc_state_e w_state;

    out_vc_slot #(
      .BUF_DEPTH (BUF_DEPTH),
      .CW        (CW)
    ) u_slot (
      .clk            (clk),
      .rst            (rst),
      .i_alloc        (allocValid && w_alloc_oh && allocVC[j]),
      .i_flit         (flitSent && w_flit_oh && flitVC[j]),
      .i_tail         (flitTail),
      .i_credit       (creditIn && w_cred_oh && creditVC[j]),
      .o_state        (w_state),
      .o_cnt          (creditCnt[j*CW +: CW]),
      .o_avail        (outVCAvailable[j]),
      .o_credit_avail (creditAvail[j]),
      .o_err          (w_slot_err[j])
    );

    assign dbgState[j*2 +: 2] = w_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= r_proto_err || w_vec_err || (|w_slot_err);
    end
  end

  assign protoErr = r_proto_err;

endmodule

// File: tb/tb_out_vc_state_ctrl.sv
// Directed bench for out_vc_state_ctrl (V=4, BUF_DEPTH=4, CW=3).
// Each driven cycle pushes the hand-computed post-edge output snapshot;
// a monitor pops and compares one snapshot after every rising edge.
module tb_out_vc_state_ctrl;

  localparam int V  = 4;
  localparam int CW = 3;
  localparam int W  = V + V + V*CW + 1 + 2*V;  // 29-bit snapshot

  logic            clk;
  logic            rst;
  logic            allocValid;
  logic [V-1:0]    allocVC;
  logic            flitSent;
  logic [V-1:0]    flitVC;
  logic            flitTail;
  logic            creditIn;
  logic [V-1:0]    creditVC;
  logic [V-1:0]    outVCAvailable;
  logic [V-1:0]    creditAvail;
  logic [V*CW-1:0] creditCnt;
  logic            protoErr;
  logic [2*V-1:0]  dbgState;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_tests;
  int           n_fail;
  bit           done;

  out_vc_state_ctrl #(.V(4), .BUF_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .allocValid     (allocValid),
    .allocVC        (allocVC),
    .flitSent       (flitSent),
    .flitVC         (flitVC),
    .flitTail       (flitTail),
    .creditIn       (creditIn),
    .creditVC       (creditVC),
    .outVCAvailable (outVCAvailable),
    .creditAvail    (creditAvail),
    .creditCnt      (creditCnt),
    .protoErr       (protoErr),
    .dbgState       (dbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- expected-value helper ----------------
  // Arguments listed VC3..VC0. States: 0 IDLE, 1 ACTIVE, 2 DRAIN.
  function automatic logic [W-1:0] ex(input logic [3:0] av, input logic [3:0] ca,
                                      input int c3, input int c2, input int c1, input int c0,
                                      input logic er,
                                      input int s3, input int s2, input int s1, input int s0);
    logic [11:0] c;
    logic [7:0]  s;
    c = {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    s = {2'(s3), 2'(s2), 2'(s1), 2'(s0)};
    return {av, ca, c, er, s};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic [3:0] avc, input logic [3:0] fvc,
                       input logic ft, input logic [3:0] cvc,
                       input logic [W-1:0] e, input string nm);
    @(negedge clk);
    rst        = r;
    allocValid = (avc != 4'b0000);
    allocVC    = avc;
    flitSent   = (fvc != 4'b0000);
    flitVC     = fvc;
    flitTail   = ft;
    creditIn   = (cvc != 4'b0000);
    creditVC   = cvc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [W-1:0] act;
      logic [W-1:0] e;
      string        nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {outVCAvailable, creditAvail, creditCnt, protoErr, dbgState};
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got avail=%b cav=%b cnt=%h err=%b st=%h, expected avail=%b cav=%b cnt=%h err=%b st=%h",
                 nm, act[28:25], act[24:21], act[20:9], act[8], act[7:0],
                 e[28:25], e[24:21], e[20:9], e[8], e[7:0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #20000;
    if (!done) begin
      n_fail++;
      $display("FAIL watchdog: bench did not complete, got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] RST_V;

  initial begin
    n_tests = 0; n_fail = 0; done = 1'b0;
    rst = 1'b1; allocValid = 0; allocVC = 0; flitSent = 0; flitVC = 0;
    flitTail = 0; creditIn = 0; creditVC = 0;
    RST_V = ex(4'b1111, 4'b1111, 4, 4, 4, 4, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // Reset and idle
    drive(1, 0, 0, 0, 0, RST_V, "reset");
    drive(0, 0, 0, 0, 0, RST_V, "idle");

    // Full packet on VC2, then credit drain
    drive(0, 4'b0100, 0, 0, 0, ex(4'b1011, 4'b1111, 4, 4, 4, 4, 0, 0, 1, 0, 0), "alloc_vc2");
    drive(0, 0, 4'b0100, 0, 0, ex(4'b1011, 4'b1111, 4, 3, 4, 4, 0, 0, 1, 0, 0), "vc2_body1");
    drive(0, 0, 4'b0100, 0, 0, ex(4'b1011, 4'b1111, 4, 2, 4, 4, 0, 0, 1, 0, 0), "vc2_body2");
    drive(0, 0, 4'b0100, 0, 0, ex(4'b1011, 4'b1111, 4, 1, 4, 4, 0, 0, 1, 0, 0), "vc2_body3");
    drive(0, 0, 4'b0100, 1, 0, ex(4'b1011, 4'b1011, 4, 0, 4, 4, 0, 0, 2, 0, 0), "vc2_tail");
    drive(0, 0, 0, 0, 4'b0100, ex(4'b1011, 4'b1111, 4, 1, 4, 4, 0, 0, 2, 0, 0), "vc2_cred1");
    drive(0, 0, 0, 0, 4'b0100, ex(4'b1011, 4'b1111, 4, 2, 4, 4, 0, 0, 2, 0, 0), "vc2_cred2");
    drive(0, 0, 0, 0, 4'b0100, ex(4'b1011, 4'b1111, 4, 3, 4, 4, 0, 0, 2, 0, 0), "vc2_cred3");
    drive(0, 0, 0, 0, 4'b0100, ex(4'b1111, 4'b1111, 4, 4, 4, 4, 0, 0, 0, 0, 0), "vc2_release");

    // Same-cycle flit and credit on VC1 at count 2
    drive(0, 4'b0010, 0, 0, 0, ex(4'b1101, 4'b1111, 4, 4, 4, 4, 0, 0, 0, 1, 0), "alloc_vc1");
    drive(0, 0, 4'b0010, 0, 0, ex(4'b1101, 4'b1111, 4, 4, 3, 4, 0, 0, 0, 1, 0), "vc1_body1");
    drive(0, 0, 4'b0010, 0, 0, ex(4'b1101, 4'b1111, 4, 4, 2, 4, 0, 0, 0, 1, 0), "vc1_body2");
    drive(0, 0, 4'b0010, 0, 4'b0010, ex(4'b1101, 4'b1111, 4, 4, 2, 4, 0, 0, 0, 1, 0), "vc1_flit_cred");

    // Tail and credit together at full count on VC3: DRAIN, then IDLE a cycle later
    drive(0, 4'b1000, 0, 0, 0, ex(4'b0101, 4'b1111, 4, 4, 2, 4, 0, 1, 0, 1, 0), "alloc_vc3");
    drive(0, 0, 4'b1000, 1, 4'b1000, ex(4'b0101, 4'b1111, 4, 4, 2, 4, 0, 2, 0, 1, 0), "vc3_tail_cred");
    drive(0, 0, 0, 0, 0, ex(4'b1101, 4'b1111, 4, 4, 2, 4, 0, 0, 0, 1, 0), "vc3_release");

    // Alloc to an ACTIVE VC: ignored, sticky error
    drive(0, 4'b0010, 0, 0, 0, ex(4'b1101, 4'b1111, 4, 4, 2, 4, 1, 0, 0, 1, 0), "err_alloc_active");
    drive(0, 0, 0, 0, 0, ex(4'b1101, 4'b1111, 4, 4, 2, 4, 1, 0, 0, 1, 0), "err_sticky");
    drive(1, 0, 0, 0, 0, RST_V, "err_clear_rst");

    // Flit on an IDLE VC
    drive(0, 0, 4'b0001, 0, 0, ex(4'b1111, 4'b1111, 4, 4, 4, 4, 1, 0, 0, 0, 0), "err_flit_idle");
    drive(1, 0, 0, 0, 0, RST_V, "rst2");

    // Flit at count 0 on VC0
    drive(0, 4'b0001, 0, 0, 0, ex(4'b1110, 4'b1111, 4, 4, 4, 4, 0, 0, 0, 0, 1), "alloc_vc0");
    drive(0, 0, 4'b0001, 0, 0, ex(4'b1110, 4'b1111, 4, 4, 4, 3, 0, 0, 0, 0, 1), "vc0_b1");
    drive(0, 0, 4'b0001, 0, 0, ex(4'b1110, 4'b1111, 4, 4, 4, 2, 0, 0, 0, 0, 1), "vc0_b2");
    drive(0, 0, 4'b0001, 0, 0, ex(4'b1110, 4'b1111, 4, 4, 4, 1, 0, 0, 0, 0, 1), "vc0_b3");
    drive(0, 0, 4'b0001, 0, 0, ex(4'b1110, 4'b1110, 4, 4, 4, 0, 0, 0, 0, 0, 1), "vc0_b4");
    drive(0, 0, 4'b0001, 0, 0, ex(4'b1110, 4'b1110, 4, 4, 4, 0, 1, 0, 0, 0, 1), "err_flit_cnt0");
    drive(1, 0, 0, 0, 0, RST_V, "rst3");

    // Credit at full count with no flit
    drive(0, 0, 0, 0, 4'b1000, ex(4'b1111, 4'b1111, 4, 4, 4, 4, 1, 0, 0, 0, 0), "err_credit_full");
    drive(1, 0, 0, 0, 0, RST_V, "rst4");

    // Malformed alloc vector alongside a legal flit, then reset mid-packet
    drive(0, 4'b0001, 0, 0, 0, ex(4'b1110, 4'b1111, 4, 4, 4, 4, 0, 0, 0, 0, 1), "alloc_vc0_b");
    drive(0, 0, 4'b0001, 0, 0, ex(4'b1110, 4'b1111, 4, 4, 4, 3, 0, 0, 0, 0, 1), "vc0_flit_a");
    drive(0, 4'b0110, 4'b0001, 0, 0, ex(4'b1110, 4'b1111, 4, 4, 4, 2, 1, 0, 0, 0, 1), "err_alloc_not_onehot");
    drive(0, 0, 4'b0001, 0, 0, ex(4'b1110, 4'b1111, 4, 4, 4, 1, 1, 0, 0, 0, 1), "vc0_flit_c");
    drive(1, 0, 0, 0, 0, RST_V, "rst_mid_packet");
    drive(0, 0, 0, 0, 0, RST_V, "post_rst_idle");

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: got %0d pending, expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/out_vc_state_ctrl.md
# out_vc_state_ctrl

Per-output-port output-VC state controller that owns the lifecycle of every downstream VC. It takes grants from the VC allocator and flit departures from the switch, and tracks credits returned by the downstream router. From these it produces the `outVCAvailable` vector consumed by the VC allocator's input-VC stage and the per-VC credit-available vector consumed by the switch allocator. One instance sits at each of the router's N output ports.

## Interface
Parameters:
- `V`, default 4: virtual channels per port; matches the global `V`.
- `BUF_DEPTH`, default 4: downstream buffer slots per VC, which is also the initial credit count.
- `CW`, default `$clog2(BUF_DEPTH+1)`: credit counter width. Derived; do not override.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `allocValid` in 1: VC allocator granted an output VC on this port this cycle.
- `allocVC` in V: one-hot granted output VC.
- `flitSent` in 1: a flit leaves this port this cycle.
- `flitVC` in V: one-hot VC of the departing flit.
- `flitTail` in 1: the departing flit is a tail, including head+tail single-flit packets.
- `creditIn` in 1: downstream returned one credit.
- `creditVC` in V: one-hot VC of the returned credit.
- `outVCAvailable` out V: bit j = VC j is IDLE, i.e. free for allocation.
- `creditAvail` out V: bit j = VC j credit count is nonzero.
- `creditCnt` out V*CW: packed counts; VC j occupies bits `[j*CW +: CW]`.
- `protoErr` out 1: sticky protocol-violation flag.

## Operation
- Each VC j runs a 3-state FSM together with a CW-bit credit counter.
  - IDLE -> ACTIVE on a legal alloc to j.
  - ACTIVE -> DRAIN on a legal flit to j with `flitTail`=1.
  - DRAIN -> IDLE when the post-update count equals BUF_DEPTH.
  - There are no other transitions.
- Counter update: `next = cnt - sent_j + ret_j`. Simultaneous send and return on the same VC leave the count unchanged.
- Legality rules:
  - An alloc is legal only if `allocVC` is one-hot and the target VC is IDLE.
  - A flit is legal only if `flitVC` is one-hot, the target is ACTIVE, and its count is greater than 0.
  - A credit is legal only if `creditVC` is one-hot and the count is less than BUF_DEPTH, or the count equals BUF_DEPTH with a legal flit on the same VC in the same cycle.
- Any illegal event:
  - is ignored, with no state or counter change from that event;
  - sets `protoErr` on the next edge;
  - leaves other legal events in the same cycle to take effect normally.
- `protoErr` clears only on `rst`.
- Outputs are registered decodes of state and count: `outVCAvailable[j]` = (state==IDLE) and `creditAvail[j]` = (cnt != 0).

## Timing
- Reset values: all FSMs IDLE; all counts = BUF_DEPTH; `outVCAvailable` = all ones; `creditAvail` = all ones; `creditCnt` = BUF_DEPTH in every field; `protoErr` = 0.
- Reset asserted mid-packet returns every VC to IDLE with full credits on the next edge. In-flight credits are discarded.
- Alloc at cycle t: `outVCAvailable[j]` = 0 from t+1. A repeat alloc to j at cycle t is legal; at t+1 it is an error.
- Flit at cycle t: count and `creditAvail` reflect it at t+1.
- Tail at t moves the VC to DRAIN at t+1. The VC re-enters IDLE at the edge after the last credit returns, so it is never IDLE before t+2.
- A VC in DRAIN that is already full (tail sent and its credit returned in the same cycle) goes IDLE one cycle later.
- A non-tail flit never releases the VC. Allocations on different VCs proceed independently in the same cycle.

## Structure
- Place state encodings (`VC_IDLE`=2'd0, `VC_ACTIVE`=2'd1, `VC_DRAIN`=2'd2) and the `V`/`BUF_DEPTH` defaults in the shared router defines header, next to `N` and `V`.
- Use one sub-module, `out_vc_slot`: a single VC's FSM, counter and per-VC error term.
  - Generate it V times.
  - The top level performs one-hot checks, OR-reduces the error terms and packs the outputs.
- Target size is about 200 lines total.

## Test plan
- Reset then idle: `outVCAvailable`=4'b1111, `creditAvail`=4'b1111, every count = 4, `protoErr`=0.
- Alloc VC2 at t; send 3 body flits and 1 tail on VC2, no credits returned:
  - `outVCAvailable`=4'b1011 from t+1;
  - count goes 4→0 and `creditAvail[2]`=0;
  - VC2 is in DRAIN.
  - Return 4 credits: VC2 is available one cycle after the 4th credit.
- Same-cycle flit and credit on VC1 at count 2: count stays 2 and there is no error.
- Alloc to an ACTIVE VC, flit on an IDLE VC, flit at count 0, and credit at count 4 with no flit, each applied separately: state and counts are unchanged and `protoErr`=1 on the next edge, sticky until `rst`.
- `allocVC`=4'b0110: no VC is allocated and `protoErr`=1.
- `rst` asserted while VC0 is ACTIVE with count 1: next edge returns all reset values.
